// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between mem_port_arbiter and its clients: IF fetch port, DM load/store port,
// memory side, and the core-facing stall / protocol-error flags.
interface mem_port_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 9
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_ack;
   logic [DATA_W-1:0] if_rdata;

   logic              dm_re;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic              dm_ack;
   logic [DATA_W-1:0] dm_rdata;

   logic              mem_re;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   logic              stall;
   logic              proto_err;

   modport slave (
      input  if_req, if_addr, dm_re, dm_we, dm_addr, dm_wdata, mem_rdata,
      output if_ack, if_rdata, dm_ack, dm_rdata,
             mem_re, mem_we, mem_addr, mem_wdata, stall, proto_err
   );

   modport master (
      output if_req, if_addr, dm_re, dm_we, dm_addr, dm_wdata, mem_rdata,
      input  if_ack, if_rdata, dm_ack, dm_rdata,
             mem_re, mem_we, mem_addr, mem_wdata, stall, proto_err
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the IF fetch port and the DM load/store port,
// sequencing each access IDLE -> ISSUE -> (WAIT) -> RESP with a bounded DM streak.
module mem_port_arbiter #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 9,
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 4
) (
   input logic               clk,
   input logic               reset,
   mem_port_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   typedef enum logic {SRC_IF, SRC_DM} src_t;

   localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam int STK_W = $clog2(STARVE_MAX + 1);

   state_t            state, state_nxt;
   src_t              winner_q, winner_nxt;
   logic              wr_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] if_rdata_q;
   logic [DATA_W-1:0] dm_rdata_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [STK_W-1:0]  streak_q;
   logic              proto_err_q;

   logic dm_req, any_req, if_starved;
   logic if_ack_c, dm_ack_c, mem_re_c, mem_we_c;

   assign dm_req     = bus.dm_re | bus.dm_we;
   assign any_req    = bus.if_req | dm_req;
   assign if_starved = (streak_q == STK_W'(STARVE_MAX));

   // DM is the default winner; IF takes the slot when alone or once DM has used its streak.
   assign winner_nxt = (bus.if_req && (!dm_req || if_starved)) ? SRC_IF : SRC_DM;

   // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (any_req) state_nxt = ISSUE;
         ISSUE:   state_nxt = wr_q ? RESP : WAIT;
         WAIT:    if (cnt_q == '0) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         winner_q    <= SRC_IF;
         wr_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
         cnt_q       <= '0;
         streak_q    <= '0;
         proto_err_q <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (any_req) begin
                  // read+write together resolves to a write
                  winner_q <= winner_nxt;
                  wr_q     <= (winner_nxt == SRC_DM) && bus.dm_we;
                  addr_q   <= (winner_nxt == SRC_IF) ? bus.if_addr : bus.dm_addr;
                  if (winner_nxt == SRC_DM && bus.dm_we) wdata_q <= bus.dm_wdata;
               end
               if (!bus.if_req || winner_nxt == SRC_IF) streak_q <= '0;
               else if (!if_starved)                     streak_q <= streak_q + 1'b1;
               if (bus.dm_re && bus.dm_we) proto_err_q <= 1'b1;
            end
            ISSUE: cnt_q <= CNT_W'(MEM_LAT - 1);
            WAIT: begin
               if (cnt_q == '0) begin
                  if (winner_q == SRC_IF) if_rdata_q <= bus.mem_rdata;
                  else                    dm_rdata_q <= bus.mem_rdata;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // NOTE: every output gets a default before the case so no path can infer a latch.
   always_comb begin
      if_ack_c = 1'b0;
      dm_ack_c = 1'b0;
      mem_re_c = 1'b0;
      mem_we_c = 1'b0;
      unique case (state)
         ISSUE: begin
            mem_re_c = !wr_q;
            mem_we_c = wr_q;
         end
         RESP: begin
            if_ack_c = (winner_q == SRC_IF);
            dm_ack_c = (winner_q == SRC_DM);
         end
         default: ;
      endcase
   end

   assign bus.if_ack    = if_ack_c;
   assign bus.dm_ack    = dm_ack_c;
   assign bus.mem_re    = mem_re_c;
   assign bus.mem_we    = mem_we_c;
   assign bus.mem_addr  = (state != IDLE) ? addr_q : '0;
   assign bus.mem_wdata = wdata_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.dm_rdata  = dm_rdata_q;
   assign bus.proto_err = proto_err_q;
   // gated by reset so the core sees no stall while the arbiter is held cleared
   assign bus.stall     = reset & any_req & ~(if_ack_c | dm_ack_c);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a transaction-timestamp model checked every cycle,
// plus literal expectations for the fetch, write, starvation, protocol-error and reset cases.
module tb_mem_port_arbiter;
   localparam int DATA_W     = 32;
   localparam int ADDR_W     = 9;
   localparam int MEM_LAT    = 2;
   localparam int STARVE_MAX = 4;

   typedef enum logic {P_IF, P_DM} port_e;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   mem_port_arbiter #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- memory: contents are a fixed pattern until written ----------------
   function automatic logic [31:0] init_word(input int a);
      return (a == 'h010) ? 32'hDEAD_BEEF : (32'hC0DE_0000 | 32'(a));
   endfunction

   logic [31:0] mem    [int];
   logic [31:0] shadow [int];

   function automatic logic [31:0] mem_rd(input int a);
      return mem.exists(a) ? mem[a] : init_word(a);
   endfunction

   function automatic logic [31:0] sh_rd(input int a);
      return shadow.exists(a) ? shadow[a] : init_word(a);
   endfunction

   logic [31:0] rd_pipe [MEM_LAT] = '{default: 32'h0};
   logic        rd_vld  [MEM_LAT] = '{default: 1'b0};

   always @(posedge clk) begin
      rd_vld[0]  <= bus.mem_re;
      rd_pipe[0] <= mem_rd(int'(bus.mem_addr));
      for (int i = 1; i < MEM_LAT; i++) begin
         rd_vld[i]  <= rd_vld[i-1];
         rd_pipe[i] <= rd_pipe[i-1];
      end
      if (bus.mem_we) mem[int'(bus.mem_addr)] = bus.mem_wdata;
   end

   assign bus.mem_rdata = rd_vld[MEM_LAT-1] ? rd_pipe[MEM_LAT-1] : 32'hBAD0_BAD0;

   // ---------------- reference model: one transaction described by its timestamps ----------------
   // Cycle n is the interval after rising edge n. A grant at edge g issues in cycle g and
   // acks in cycle g+1 (write) or g+1+MEM_LAT (read); the cycle after the ack is idle.
   int          cyc = 0;
   bit          busy = 1'b0;
   port_e       m_who = P_IF;
   bit          m_wr = 1'b0;
   logic [8:0]  m_addr = '0;
   logic [31:0] m_wdata = '0;
   int          m_g = 0;
   int          m_ack = 0;
   int          m_streak = 0;
   bit          m_proto = 1'b0;
   logic [31:0] m_if_rdata = '0;
   logic [31:0] m_dm_rdata = '0;
   port_e       model_log [$];

   always @(posedge clk or negedge reset) begin : model
      bit    want_if, want_dm;
      port_e who;
      if (!reset) begin
         busy       = 1'b0;
         m_streak   = 0;
         m_proto    = 1'b0;
         m_if_rdata = '0;
         m_dm_rdata = '0;
      end else begin
         cyc++;
         if (busy && cyc == m_ack) begin
            if (m_wr)              shadow[int'(m_addr)] = m_wdata;
            else if (m_who == P_IF) m_if_rdata = sh_rd(int'(m_addr));
            else                   m_dm_rdata = sh_rd(int'(m_addr));
         end
         if (!busy || cyc - 1 > m_ack) begin
            want_if = bus.if_req;
            want_dm = bus.dm_re | bus.dm_we;
            if (!want_dm)                     who = P_IF;
            else if (!want_if)                who = P_DM;
            else if (m_streak >= STARVE_MAX)  who = P_IF;
            else                              who = P_DM;
            if (!want_if || who == P_IF) m_streak = 0;
            else if (want_dm)            m_streak = (m_streak + 1 > STARVE_MAX) ? STARVE_MAX : m_streak + 1;
            if (want_if || want_dm) begin
               busy    = 1'b1;
               m_who   = who;
               m_wr    = (who == P_DM) && bus.dm_we;
               m_addr  = (who == P_IF) ? bus.if_addr : bus.dm_addr;
               m_wdata = bus.dm_wdata;
               m_g     = cyc;
               m_ack   = m_wr ? cyc + 1 : cyc + 1 + MEM_LAT;
               if (bus.dm_re && bus.dm_we) m_proto = 1'b1;
               model_log.push_back(who);
            end
         end
      end
   end

   bit cmp_en = 1'b0;

   always @(negedge clk) begin : compare
      bit          act, e_re, e_we, e_ifa, e_dma, e_stall;
      logic [31:0] e_addr;
      if (cmp_en) begin
         act     = reset && busy && cyc >= m_g && cyc <= m_ack;
         e_re    = act && cyc == m_g && !m_wr;
         e_we    = act && cyc == m_g && m_wr;
         e_ifa   = act && cyc == m_ack && m_who == P_IF;
         e_dma   = act && cyc == m_ack && m_who == P_DM;
         e_addr  = act ? 32'(m_addr) : 32'h0;
         e_stall = reset && (bus.if_req || bus.dm_re || bus.dm_we) && !(e_ifa || e_dma);
         check("cyc mem_re",    32'(bus.mem_re),    32'(e_re));
         check("cyc mem_we",    32'(bus.mem_we),    32'(e_we));
         check("cyc mem_addr",  32'(bus.mem_addr),  e_addr);
         if (e_we) check("cyc mem_wdata", bus.mem_wdata, m_wdata);
         check("cyc if_ack",    32'(bus.if_ack),    32'(e_ifa));
         check("cyc dm_ack",    32'(bus.dm_ack),    32'(e_dma));
         check("cyc if_rdata",  bus.if_rdata,       m_if_rdata);
         check("cyc dm_rdata",  bus.dm_rdata,       m_dm_rdata);
         check("cyc stall",     32'(bus.stall),     32'(e_stall));
         check("cyc proto_err", 32'(bus.proto_err), 32'(m_proto));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic drive_pt();
      @(negedge clk);
      #2;
   endtask

   // k = index of the negedge (0 = first after the request drive) where the ack showed.
   task automatic wait_ack(input bit is_if, input string name, output int k);
      k = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (is_if ? bus.if_ack : bus.dm_ack) begin
            k = i;
            break;
         end
      end
      if (k < 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: no ack within 20 cycles, required one", name);
      end
   endtask

   task automatic if_read(input logic [8:0] a, input string name, output logic [31:0] data);
      int k;
      drive_pt();
      bus.if_addr = a;
      bus.if_req  = 1'b1;
      wait_ack(1'b1, name, k);
      check({name, " latency"}, 32'(k), 32'd3);
      data = bus.if_rdata;
      #2 bus.if_req = 1'b0;
   endtask

   task automatic dm_access(input bit re, input bit we, input logic [8:0] a, input logic [31:0] wd,
                            input int exp_k, input string name, output logic [31:0] data);
      int k;
      drive_pt();
      bus.dm_addr  = a;
      bus.dm_wdata = wd;
      bus.dm_re    = re;
      bus.dm_we    = we;
      wait_ack(1'b0, name, k);
      check({name, " latency"}, 32'(k), 32'(exp_k));
      data = bus.dm_rdata;
      #2;
      bus.dm_re = 1'b0;
      bus.dm_we = 1'b0;
   endtask

   // ---------------- directed tests ----------------
   initial begin
      logic [31:0] d;
      logic [3:0]  re_seen, ack_seen;
      port_e       dut_log [$];
      port_e       exp_seq [6] = '{P_DM, P_DM, P_DM, P_DM, P_IF, P_DM};
      int          guard;

      bus.if_req = 1'b0; bus.if_addr = '0;
      bus.dm_re = 1'b0;  bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
      #1 cmp_en = 1'b1;
      repeat (3) drive_pt();
      reset = 1'b1;

      // reset state
      @(negedge clk);
      check("rst outputs", {26'h0, bus.if_ack, bus.dm_ack, bus.mem_re, bus.mem_we, bus.stall, bus.proto_err}, 32'h0);
      check("rst if_rdata", bus.if_rdata, 32'h0);

      // 1: IF-only read of 0x010
      drive_pt();
      bus.if_addr = 9'h010;
      bus.if_req  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         re_seen[i]  = bus.mem_re;
         ack_seen[i] = bus.if_ack;
      end
      check("t1 mem_re timing", 32'(re_seen), 32'h1);
      check("t1 if_ack timing", 32'(ack_seen), 32'h8);
      check("t1 if_rdata", bus.if_rdata, 32'hDEAD_BEEF);
      #2 bus.if_req = 1'b0;

      // 2: DM write to 0x1FF, then read back
      drive_pt();
      bus.dm_addr  = 9'h1FF;
      bus.dm_wdata = 32'h1234_5678;
      bus.dm_we    = 1'b1;
      @(negedge clk);
      check("t2 mem_we", {bus.mem_we, bus.mem_re}, 2'b10);
      check("t2 mem_addr", 32'(bus.mem_addr), 32'h1FF);
      check("t2 mem_wdata", bus.mem_wdata, 32'h1234_5678);
      @(negedge clk);
      check("t2 dm_ack", 32'(bus.dm_ack), 32'h1);
      #2 bus.dm_we = 1'b0;
      dm_access(1'b1, 1'b0, 9'h1FF, 32'h0, 3, "t2 readback", d);
      check("t2 readback data", d, 32'h1234_5678);

      // 3: both ports held requesting -> DM x4 then IF
      drive_pt();
      model_log.delete();
      bus.if_addr = 9'h011;
      bus.dm_addr = 9'h022;
      bus.if_req  = 1'b1;
      bus.dm_re   = 1'b1;
      guard = 0;
      while (dut_log.size() < 6 && guard < 80) begin
         @(negedge clk);
         guard++;
         if (bus.dm_ack) dut_log.push_back(P_DM);
         if (bus.if_ack) dut_log.push_back(P_IF);
      end
      #2;
      bus.if_req = 1'b0;
      bus.dm_re  = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (i < dut_log.size()) check($sformatf("t3 dut grant %0d", i), 32'(dut_log[i]), 32'(exp_seq[i]));
         else check($sformatf("t3 dut grant %0d missing", i), 32'hFFFF_FFFF, 32'(exp_seq[i]));
         if (i < model_log.size()) check($sformatf("t3 model grant %0d", i), 32'(model_log[i]), 32'(exp_seq[i]));
         else check($sformatf("t3 model grant %0d missing", i), 32'hFFFF_FFFF, 32'(exp_seq[i]));
      end

      // 4: read+write together -> write, sticky proto_err
      drive_pt();
      check("t4 proto_err before", 32'(bus.proto_err), 32'h0);
      dm_access(1'b1, 1'b1, 9'h005, 32'hA5A5_0005, 1, "t4 rw", d);
      check("t4 proto_err set", 32'(bus.proto_err), 32'h1);
      if_read(9'h005, "t4 if readback", d);
      check("t4 readback data", d, 32'hA5A5_0005);
      check("t4 proto_err sticky", 32'(bus.proto_err), 32'h1);

      // 6: dm_addr changed mid-access has no effect
      drive_pt();
      bus.dm_addr = 9'h020;
      bus.dm_re   = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check($sformatf("t6 mem_addr k%0d", i), 32'(bus.mem_addr), 32'h020);
         check($sformatf("t6 stall k%0d", i), 32'(bus.stall), (i == 3) ? 32'h0 : 32'h1);
         if (i == 1) #2 bus.dm_addr = 9'h030;
      end
      check("t6 dm_ack", 32'(bus.dm_ack), 32'h1);
      check("t6 dm_rdata", bus.dm_rdata, 32'hC0DE_0020);
      #2 bus.dm_re = 1'b0;

      // 5: reset during WAIT clears everything at once, then a fresh read works
      drive_pt();
      bus.if_addr = 9'h033;
      bus.if_req  = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check("t5 async flags", {26'h0, bus.if_ack, bus.dm_ack, bus.mem_re, bus.mem_we, bus.stall, bus.proto_err}, 32'h0);
      check("t5 async mem_addr", 32'(bus.mem_addr), 32'h0);
      check("t5 async mem_wdata", bus.mem_wdata, 32'h0);
      check("t5 async if_rdata", bus.if_rdata, 32'h0);
      check("t5 async dm_rdata", bus.dm_rdata, 32'h0);
      ack_seen = '0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         ack_seen[i] = bus.if_ack | bus.dm_ack;
      end
      check("t5 no ack in reset", 32'(ack_seen), 32'h0);
      #2 bus.if_req = 1'b0;
      drive_pt();
      reset = 1'b1;
      if_read(9'h033, "t5 after reset", d);
      check("t5 after reset data", d, 32'hC0DE_0033);

      repeat (3) drive_pt();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
